// File: rtl/arp_sched_pkg.sv
// Shared types and constants for the ARP table sequencer.
package arp_sched_pkg;

  localparam int unsigned ARP_TBL_DEPTH = 32;
  localparam int unsigned ARP_ENTRY_W   = 96;

  // Entry layout: [95:80] reserved, [79:32] MAC, [31:0] IPv4
  localparam int unsigned MAC_HI = 79;
  localparam int unsigned MAC_LO = 32;
  localparam int unsigned IP_HI  = 31;
  localparam int unsigned IP_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_SCAN,
    ST_RESP
  } state_t;

  // Which requester class owned the table last; breaks host/datapath ties.
  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_DP   = 1'b1
  } grant_t;

endpackage

// File: rtl/arp_table_ram.sv
// Single-port ARP table storage with a registered (1-cycle) read port.
module arp_table_ram #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage and read register; reset wipes every entry to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we) begin
        mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/arp_table_sched.sv
// ARP table owner: arbitrates datapath lookups against host reads/writes
// and resolves next-hop MACs with a one-entry-per-cycle scan.
module arp_table_sched
  import arp_sched_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned TBL_DEPTH          = ARP_TBL_DEPTH,
  parameter int unsigned TBL_ADDR_W         = 5
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESET,
  input  logic                            lkp_req,
  input  logic [31:0]                     lkp_nh,
  output logic                            lkp_ack,
  output logic                            lkp_hit,
  output logic [47:0]                     lkp_mac,
  input  logic                            tbl_wr_req,
  input  logic [TBL_ADDR_W-1:0]           tbl_wr_addr,
  input  logic [3*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  output logic                            tbl_wr_ack,
  input  logic                            tbl_rd_req,
  input  logic [TBL_ADDR_W-1:0]           tbl_rd_addr,
  output logic [3*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  output logic                            tbl_rd_ack,
  input  logic                            cnt_clear,
  output logic [31:0]                     arp_hit_count,
  output logic [31:0]                     arp_miss_count
);

  localparam int unsigned ENTRY_W = 3 * C_S_AXI_DATA_WIDTH;
  localparam logic [TBL_ADDR_W-1:0] LAST_IDX = TBL_ADDR_W'(TBL_DEPTH - 1);

  state_t                 state_q, state_d;
  grant_t                 last_q, last_d;
  logic [31:0]            nh_q, nh_d;
  logic [TBL_ADDR_W-1:0]  issue_idx_q, issue_idx_d;
  logic                   issue_done_q, issue_done_d;
  logic                   cmp_valid_q, cmp_valid_d;
  logic [TBL_ADDR_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic                   lkp_ack_q, lkp_ack_d;
  logic                   lkp_hit_q, lkp_hit_d;
  logic [47:0]            lkp_mac_q, lkp_mac_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   rd_ack_q, rd_ack_d;
  logic [ENTRY_W-1:0]     rd_data_q, rd_data_d;
  logic [31:0]            hit_cnt_q, hit_cnt_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;

  logic                   ram_we;
  logic [TBL_ADDR_W-1:0]  ram_addr;
  logic [ENTRY_W-1:0]     ram_rdata;
  logic                   host_req;
  logic                   grant_dp;
  logic                   match;

  arp_table_ram #(
    .DEPTH  (TBL_DEPTH),
    .ADDR_W (TBL_ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk   (AXI_ACLK),
    .rst   (AXI_RESET),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (tbl_wr_data),
    .rdata (ram_rdata)
  );

  // Next-state, RAM control, output and counter computation.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    nh_d         = nh_q;
    issue_idx_d  = issue_idx_q;
    issue_done_d = issue_done_q;
    cmp_valid_d  = cmp_valid_q;
    cmp_idx_d    = cmp_idx_q;
    lkp_ack_d    = 1'b0;
    lkp_hit_d    = lkp_hit_q;
    lkp_mac_d    = lkp_mac_q;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    rd_data_d    = rd_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    ram_we       = 1'b0;
    ram_addr     = issue_idx_q;
    host_req     = tbl_wr_req | tbl_rd_req;
    grant_dp     = lkp_req & (~host_req | (last_q == GNT_HOST));
    // Empty entries (IP 0) must never match even if nh_q were 0.
    match        = cmp_valid_q
                 && (ram_rdata[IP_HI:IP_LO] == nh_q)
                 && (ram_rdata[IP_HI:IP_LO] != '0);

    case (state_q)
      ST_IDLE: begin
        if (grant_dp) begin
          last_d = GNT_DP;
          if (lkp_nh == '0) begin
            lkp_ack_d = 1'b1;
            lkp_hit_d = 1'b0;
            lkp_mac_d = '0;
            state_d   = ST_RESP;
          end else begin
            nh_d         = lkp_nh;
            issue_idx_d  = '0;
            issue_done_d = 1'b0;
            cmp_valid_d  = 1'b0;
            state_d      = ST_SCAN;
          end
        end else if (host_req) begin
          last_d  = GNT_HOST;
          state_d = tbl_wr_req ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        ram_we   = 1'b1;
        ram_addr = tbl_wr_addr;
        wr_ack_d = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RD: begin
        ram_addr = tbl_rd_addr;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rd_data_d = ram_rdata;
        rd_ack_d  = 1'b1;
        state_d   = ST_RESP;
      end
      // Issue and compare are pipelined one cycle apart; a hit abandons
      // the read issued in the same cycle.
      ST_SCAN: begin
        if (match) begin
          lkp_ack_d = 1'b1;
          lkp_hit_d = 1'b1;
          lkp_mac_d = ram_rdata[MAC_HI:MAC_LO];
          state_d   = ST_RESP;
        end else if (cmp_valid_q && (cmp_idx_q == LAST_IDX)) begin
          lkp_ack_d = 1'b1;
          lkp_hit_d = 1'b0;
          lkp_mac_d = '0;
          state_d   = ST_RESP;
        end else begin
          cmp_valid_d = ~issue_done_q;
          cmp_idx_d   = issue_idx_q;
          if (issue_idx_q == LAST_IDX) begin
            issue_done_d = 1'b1;
          end else begin
            issue_idx_d = issue_idx_q + 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (lkp_ack_q) begin
          if (lkp_hit_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cnt_clear) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  // FSM, pipeline and registered outputs.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q      <= ST_IDLE;
      last_q       <= GNT_HOST;
      nh_q         <= '0;
      issue_idx_q  <= '0;
      issue_done_q <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_idx_q    <= '0;
      lkp_ack_q    <= 1'b0;
      lkp_hit_q    <= 1'b0;
      lkp_mac_q    <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_data_q    <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      nh_q         <= nh_d;
      issue_idx_q  <= issue_idx_d;
      issue_done_q <= issue_done_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_idx_q    <= cmp_idx_d;
      lkp_ack_q    <= lkp_ack_d;
      lkp_hit_q    <= lkp_hit_d;
      lkp_mac_q    <= lkp_mac_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      rd_data_q    <= rd_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign lkp_ack        = lkp_ack_q;
  assign lkp_hit        = lkp_hit_q;
  assign lkp_mac        = lkp_mac_q;
  assign tbl_wr_ack     = wr_ack_q;
  assign tbl_rd_ack     = rd_ack_q;
  assign tbl_rd_data    = rd_data_q;
  assign arp_hit_count  = hit_cnt_q;
  assign arp_miss_count = miss_cnt_q;

endmodule
